// File: rtl/ble6_lut6_cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// ble6_cfg_pkg
// Shared types and constants for the BLE6 LUT6 configuration loader.
//   LUT_K      : default number of LUT select inputs
//   CFG_BITS   : truth-table size, always 2**LUT_K
//   BIT_CNT_W  : width of the shift counter; it must hold CFG_BITS+1 (the
//                saturated overshift marker) and, with the parity bit in the
//                chain, CFG_BITS+2
//   cfg_state_e: loader FSM states
// No ports (package).
// ---------------------------------------------------------------------------
package ble6_cfg_pkg;

  localparam int LUT_K     = 6;
  localparam int CFG_BITS  = 2 ** LUT_K;
  localparam int BIT_CNT_W = $clog2(CFG_BITS + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/ble6_lut6_cfg_loader_mux.sv
// ---------------------------------------------------------------------------
// lut6_mux
// Combinational 2**LUT_K:1 selector that turns the committed truth table
// into the LUT output.
// Ports:
//   active   [2**LUT_K-1:0] in  : committed truth table
//   lut6_in  [LUT_K-1:0]    in  : select inputs
//   lut6_out                out : active[lut6_in]
// ---------------------------------------------------------------------------
module lut6_mux #(
  parameter int LUT_K = 6
) (
  input  logic [(2**LUT_K)-1:0] active,
  input  logic [LUT_K-1:0]      lut6_in,
  output logic                  lut6_out
);

  assign lut6_out = active[lut6_in];

endmodule

// File: rtl/ble6_lut6_cfg_loader.sv
// ---------------------------------------------------------------------------
// ble6_lut6_cfg_loader
// 6-input LUT with a serial configuration loader. Bits shift into a shadow
// chain while prog_en is high; on the falling edge of prog_en the load is
// committed to the active table only if exactly the right number of bits
// arrived, so lut6_out never sees a partially loaded table.
//
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous, active-high, clears all state
//   prog_en    in  : high = shift one bit per cycle, falling edge = commit
//   ccff_head  in  : serial configuration data in
//   ccff_tail  out : registered serial data out (chain cascade)
//   lut6_in    in  : LUT select inputs
//   lut6_out   out : active[lut6_in], combinational
//   cfg_done   out : a valid table has been committed (sticky)
//   cfg_err    out : the last load was rejected (sticky)
//
// Build option: BLE6_LUT_CFG_PARITY_EN adds a trailing even-parity bit to
// the chain (CFG_BITS+1 long); the load commits only with a full count and
// zero XOR over the shadow chain. The parity bit is not kept in the table.
// ---------------------------------------------------------------------------
module ble6_lut6_cfg_loader #(
  parameter int LUT_K = ble6_cfg_pkg::LUT_K
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_en,
  input  logic             ccff_head,
  output logic             ccff_tail,
  input  logic [LUT_K-1:0] lut6_in,
  output logic             lut6_out,
  output logic             cfg_done,
  output logic             cfg_err
);
  import ble6_cfg_pkg::*;

  localparam int CFG_BITS = 2 ** LUT_K;
`ifdef BLE6_LUT_CFG_PARITY_EN
  localparam int CHAIN_BITS = CFG_BITS + 1;
`else
  localparam int CHAIN_BITS = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  // Count value of a complete load, and the saturation value that flags
  // overshift (one beyond complete).
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_BITS + 1);

  cfg_state_e              state_reg;
  logic [CHAIN_BITS-1:0]   shadow_reg;
  logic [CFG_BITS-1:0]     active_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    ccff_tail_reg;
  logic                    cfg_done_reg;
  logic                    cfg_err_reg;
  logic                    load_ok;

`ifdef BLE6_LUT_CFG_PARITY_EN
  assign load_ok = (bit_cnt_reg == CNT_FULL) && !(^shadow_reg);
`else
  assign load_ok = (bit_cnt_reg == CNT_FULL);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      active_reg    <= '0;
      bit_cnt_reg   <= '0;
      ccff_tail_reg <= 1'b0;
      cfg_done_reg  <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (prog_en) begin
            // First bit of a new load is taken on the same edge.
            shadow_reg    <= {shadow_reg[CHAIN_BITS-2:0], ccff_head};
            ccff_tail_reg <= shadow_reg[CHAIN_BITS-1];
            bit_cnt_reg   <= CNT_W'(1);
            cfg_done_reg  <= 1'b0;
            cfg_err_reg   <= 1'b0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (prog_en) begin
            shadow_reg    <= {shadow_reg[CHAIN_BITS-2:0], ccff_head};
            ccff_tail_reg <= shadow_reg[CHAIN_BITS-1];
            if (bit_cnt_reg != CNT_MAX) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (load_ok) begin
            state_reg <= COMMIT;
          end else begin
            // Short, overshifted or bad parity: keep the old table.
            cfg_err_reg <= 1'b1;
            bit_cnt_reg <= '0;
            state_reg   <= IDLE;
          end
        end
        COMMIT: begin
          // prog_en is deliberately ignored here; IDLE picks it up next edge.
          // The first-shifted bit sits at the top of the chain; with parity
          // enabled the parity bit is the bottom bit and is dropped.
          active_reg   <= shadow_reg[CHAIN_BITS-1 -: CFG_BITS];
          cfg_done_reg <= 1'b1;
          bit_cnt_reg  <= '0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ccff_tail = ccff_tail_reg;
  assign cfg_done  = cfg_done_reg;
  assign cfg_err   = cfg_err_reg;

  lut6_mux #(
    .LUT_K (LUT_K)
  ) u_mux (
    .active   (active_reg),
    .lut6_in  (lut6_in),
    .lut6_out (lut6_out)
  );

endmodule

// File: tb/tb_ble6_lut6_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_ble6_lut6_cfg_loader
// Self-checking bench for ble6_lut6_cfg_loader: table of load vectors plus
// hand-written sequences for reset mid-shift and prog_en re-asserted during
// the commit cycle. Expected LUT contents and tail bits go through queues.
// ---------------------------------------------------------------------------
module tb_ble6_lut6_cfg_loader;

  localparam int K  = 6;
  localparam int NB = 64;
`ifdef BLE6_LUT_CFG_PARITY_EN
  localparam int SH = NB + 1;
`else
  localparam int SH = NB;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         prog_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [K-1:0] lut6_in;
  logic         lut6_out;
  logic         cfg_done;
  logic         cfg_err;

  always #5 clk = ~clk;

  ble6_lut6_cfg_loader #(
    .LUT_K (K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_en   (prog_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .lut6_in   (lut6_in),
    .lut6_out  (lut6_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  typedef struct {
    logic [63:0] data;      // table; data[63] is shifted first
    int          nbits;     // bits shifted before prog_en drops
    int          flip;      // stream index to corrupt, -1 for none
    logic        exp_done;  // expected cfg_done after the load
    logic        exp_err;   // expected cfg_err after the load
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model;
  logic        exp_q[$];
  logic        chain_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sbit(input vec_t v, input int j);
    if (j < NB) return v.data[NB-1-j] ^ (j == v.flip);
`ifdef BLE6_LUT_CFG_PARITY_EN
    if (j == NB) return ^v.data;
`endif
    return v.data[NB-1-((j-NB) % NB)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_check(input string nm, input int idx);
    lut6_in = K'(idx);
    exp_q.push_back(model[idx]);
    #1;
    check($sformatf("%s_lut[%0d]", nm, idx), lut6_out, exp_q.pop_front());
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < NB; i++) lut_check(nm, i);
    $display("sweep %s: table %h", nm, model);
  endtask

  task automatic shift_stream(input vec_t v, input int from, input string nm);
    for (int j = from; j < v.nbits; j++) begin
      prog_en   = 1'b1;
      ccff_head = sbit(v, j);
      chain_q.push_back(ccff_head);
      tick();
      if (j == 0) begin
        check({nm, "_start_done"}, cfg_done, 0);
        check({nm, "_start_err"}, cfg_err, 0);
      end
      if (chain_q.size() > SH)
        check($sformatf("%s_tail[%0d]", nm, j), ccff_tail, chain_q.pop_front());
    end
  endtask

  task automatic end_load(input vec_t v, input string nm);
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    chain_q.delete();
    tick();
    if (v.exp_done) begin
      check({nm, "_done_edge1"}, cfg_done, 0);
      tick();
      check({nm, "_done"}, cfg_done, 1);
      check({nm, "_err"}, cfg_err, 0);
      model = v.data;
    end else begin
      check({nm, "_err"}, cfg_err, v.exp_err);
      check({nm, "_done"}, cfg_done, 0);
    end
    $display("load %s: %0d bits done=%0b err=%0b", nm, v.nbits, cfg_done, cfg_err);
    sweep(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tmp;
    vecs[0] = '{data:64'h8000_0000_0000_0000, nbits:SH,   flip:-1, exp_done:1'b1, exp_err:1'b0};
    vecs[1] = '{data:64'hFFFF_FFFF_FFFF_FFFF, nbits:SH-1, flip:-1, exp_done:1'b0, exp_err:1'b1};
    vecs[2] = '{data:64'hB5C3_0F0F_1234_5678, nbits:SH+6, flip:-1, exp_done:1'b0, exp_err:1'b1};
    vecs[3] = '{data:64'h6996_9669_9669_6996, nbits:SH,   flip:-1, exp_done:1'b1, exp_err:1'b0};
    vecs[4] = '{data:64'h0123_4567_89AB_CDEF, nbits:SH,   flip:-1, exp_done:1'b1, exp_err:1'b0};
    vecs[5] = '{data:64'hFEDC_BA98_7654_3210, nbits:SH,   flip:-1, exp_done:1'b1, exp_err:1'b0};
    vecs[6] = '{data:64'hDEAD_BEEF_0BAD_F00D, nbits:SH,   flip:-1, exp_done:1'b1, exp_err:1'b0};
    vecs[7] = '{data:64'hDEAD_BEEF_0BAD_F00D, nbits:SH,   flip:10, exp_done:1'b0, exp_err:1'b1};

    // Reset state
    reset     = 1'b1;
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    lut6_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_tail", ccff_tail, 0);
    model = '0;
    sweep("reset");

    // AND6, short load, overshift
    for (int i = 0; i < 3; i++) begin
      shift_stream(vecs[i], 0, $sformatf("v%0d", i));
      end_load(vecs[i], $sformatf("v%0d", i));
    end

    // Reset after 30 bits discards the load and the active table
    tmp       = vecs[3];
    tmp.nbits = 30;
    shift_stream(tmp, 0, "mid");
    reset   = 1'b1;
    prog_en = 1'b0;
    #1;
    check("mid_rst_done", cfg_done, 0);
    check("mid_rst_err", cfg_err, 0);
    check("mid_rst_tail", ccff_tail, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chain_q.delete();
    tick();
    model = '0;
    sweep("mid_rst");

    // XOR6 full load
    shift_stream(vecs[3], 0, "v3");
    end_load(vecs[3], "v3");

    // prog_en back high during COMMIT: commit completes, new load starts
    // from IDLE on the following edge (the bit offered in COMMIT is dropped)
    shift_stream(vecs[4], 0, "v4");
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    chain_q.delete();
    tick();
    check("re_edge1_done", cfg_done, 0);
    prog_en   = 1'b1;
    ccff_head = 1'b1;
    tick();
    check("re_commit_done", cfg_done, 1);
    check("re_commit_err", cfg_err, 0);
    model = vecs[4].data;
    lut_check("re", 0);
    lut_check("re", 21);
    lut_check("re", 63);
    ccff_head = sbit(vecs[5], 0);
    chain_q.push_back(ccff_head);
    tick();
    check("re_start_done", cfg_done, 0);
    check("re_start_err", cfg_err, 0);
    $display("reassert: commit of v4 seen, v5 load started");
    shift_stream(vecs[5], 1, "v5");
    end_load(vecs[5], "v5");

`ifdef BLE6_LUT_CFG_PARITY_EN
    for (int i = 6; i < 8; i++) begin
      shift_stream(vecs[i], 0, $sformatf("v%0d", i));
      end_load(vecs[i], $sformatf("v%0d", i));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
